player_dir_queue: RTL and testbench
===================================

# player_dir_queue

Clocked, parametrised successor to the combinational key-to-direction mapper. It decodes PS/2 make codes into per-player direction requests (1=up, 2=down, 3=left, 4=right) and filters illegal reversals. Accepted requests are buffered in a small per-player FIFO, and each player's committed direction advances by one entry per game tick. It sits between the PS/2 receiver and the lightbike game-state logic, so fast key sequences between ticks are neither lost nor merged.

## Interface
- NUM_PLAYERS, default 2: number of independent players.
- QUEUE_DEPTH, default 4: per-player FIFO entries; must be a power of 2 and at least 2.
- CNT_W, default $clog2(QUEUE_DEPTH)+1: width of each count field.
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid in that cycle.
- ps2_key_data  in  8  PS/2 scan code byte.
- keymap  in  NUM_PLAYERS*32  per player p, 4 codes at [p*32 + k*8 +: 8]; k=0..3 maps to direction k+1.
- game_tick  in  1  one-cycle strobe; pops one entry per non-empty queue.
- start  in  1  synchronous round restart.
- init_dir  in  NUM_PLAYERS*3  direction loaded on start.
- dir_out  out  NUM_PLAYERS*3  committed direction per player.
- turn_valid  out  NUM_PLAYERS  one-cycle pulse when dir_out[p] changes because of a pop.
- queue_count  out  NUM_PLAYERS*CNT_W  current occupancy per player.
- overflow  out  NUM_PLAYERS  sticky flag: a request was dropped because the queue was full.

## Operation
- Reset values: dir_out=0 (DIR_NONE), all queues empty, queue_count=0, overflow=0, turn_valid=0, break flag clear.
- Break handling: a strobe with data 8'hF0 sets the break flag. The next strobe (a release code) is consumed and clears the flag, with no enqueue. 8'hE0 strobes are ignored and leave the flag unchanged.
- Decode: on a non-break, non-ignored strobe, each player is evaluated independently.
  - If several k match within one player, the highest k wins.
  - A code present in two players' keymaps is requested for both.
- Reference direction R[p]:
  - the tail entry if queue_count[p] > 0;
  - otherwise dir_out[p].
- A candidate d is enqueued only if d != R[p] and d != opposite(R[p]). Opposite pairs are 1↔2 and 3↔4. If R[p]=0, any d is accepted.
- If the queue is full and no pop happens in the same cycle, the request is dropped and overflow[p] is set.
- game_tick: every player with queue_count > 0 pops its head into dir_out[p] and pulses turn_valid[p]. Empty queues are unaffected.
- Same cycle, same player, push and pop: the pop happens, the push is accepted even when full, and the count is unchanged. When count=1, R is the popped entry.
- start has highest priority. It:
  - clears all queues, overflow and the break flag;
  - loads dir_out[p]=init_dir[p], with values 5–7 loaded as 0;
  - ignores any strobes in the same cycle;
  - does not pulse turn_valid.
- FIFO pointers wrap modulo QUEUE_DEPTH. Count saturates at neither end, because the filtering and full rules above prevent it.

## Timing
- Key strobe in cycle N: queue_count and tail are updated at N+1; overflow is set at N+1.
- game_tick in cycle T: dir_out is updated at T+1, and turn_valid is high for cycle T+1 only.
- Minimum key-to-dir_out latency: a key at N and a tick at N+1 give dir_out at N+2.
- An asynchronous resetn assertion mid-operation clears all state immediately. Operation resumes on the first clock edge after release.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package player_ctrl_pkg holds:
  - direction constants DIR_NONE=0, DIR_UP=1, DIR_DOWN=2, DIR_LEFT=3, DIR_RIGHT=4;
  - PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - the opposite() function.
- Sub-module dir_fifo is a 3-bit wide, QUEUE_DEPTH deep FIFO with push, pop, tail, head, count and full. It is instantiated once per player in a generate loop.
- The top level holds the break flag, decode, reversal filter, dir_out, turn_valid and overflow registers.

## Test plan
- Reset, then start with init_dir = {P1=3, P0=1}: dir_out={3,1}, turn_valid=0, queue_count all 0.
- P0 at dir 1:
  - press P0 key k=1 (down): rejected, count stays 0;
  - press k=2 (left): count=1;
  - game_tick: dir_out[0]=3 one cycle later, with a single turn_valid[0] pulse.
- Break sequence F0, then the P0 left code: no enqueue. The following strobe of the P0 right code, with R=1 (up), is enqueued.
- QUEUE_DEPTH=4: push alternating legal turns 5 times without a tick. count=4 and overflow[0]=1. overflow is cleared only by start.
- Full queue with push and game_tick in the same cycle: count stays 4, the head pops, and the new entry lands at the tail after pointer wrap.
- Assert resetn low mid-queue (count=3): dir_out, queue_count, overflow and turn_valid clear asynchronously. After release, the first key strobe is accepted with R=0.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared constants for the player direction path.
//   DIR_*      : direction encodings used on dir_out and inside the queues
//   PS2_*      : PS/2 prefix bytes that are not key codes
//   opposite() : reverse of a direction (DIR_NONE maps to DIR_NONE)
package player_ctrl_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// 3-bit wide direction FIFO, one per player.
//   clock, resetn : system clock, async active-low reset
//   clear         : synchronous flush (round restart)
//   push, din     : write din at the tail
//   pop           : drop the head
//   head, tail    : oldest / newest stored entry
//   count, full   : occupancy and full flag
// Push while full is legal only together with pop; the write slot is the
// one being vacated, and the head read this cycle is still the old value.
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [2:0]       din,
  output logic [2:0]       head,
  output logic [2:0]       tail,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  import player_ctrl_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;

  assign tail_ptr = wr_ptr - AW'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign full     = (count == CNT_W'(DEPTH));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/player_dir_queue.sv
// PS/2 key codes -> per-player queued direction requests, committed per tick.
//   clock, resetn    : system clock, async active-low reset
//   ps2_key_pressed  : scan code strobe, ps2_key_data valid with it
//   keymap           : 4 codes per player (up, down, left, right)
//   game_tick        : pops one entry from every non-empty queue
//   start, init_dir  : round restart and the directions loaded by it
//   dir_out          : committed direction per player
//   turn_valid       : one-cycle pulse when dir_out changed due to a pop
//   queue_count      : queue occupancy per player
//   overflow         : sticky, a legal request was dropped on a full queue
module player_dir_queue #(
  parameter int NUM_PLAYERS = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         ps2_key_pressed,
  input  logic [7:0]                   ps2_key_data,
  input  logic [NUM_PLAYERS*32-1:0]    keymap,
  input  logic                         game_tick,
  input  logic                         start,
  input  logic [NUM_PLAYERS*3-1:0]     init_dir,
  output logic [NUM_PLAYERS*3-1:0]     dir_out,
  output logic [NUM_PLAYERS-1:0]       turn_valid,
  output logic [NUM_PLAYERS*CNT_W-1:0] queue_count,
  output logic [NUM_PLAYERS-1:0]       overflow
);
  import player_ctrl_pkg::*;

  logic                   brk;
  logic                   key_ev;
  logic [2:0]             cand    [NUM_PLAYERS];
  logic [2:0]             ref_dir [NUM_PLAYERS];
  logic [2:0]             head    [NUM_PLAYERS];
  logic [2:0]             tail    [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] full;
  logic [NUM_PLAYERS-1:0] legal;
  logic [NUM_PLAYERS-1:0] push;
  logic [NUM_PLAYERS-1:0] pop;

  // A strobe is a direction request only outside a break sequence and when
  // it is not itself a prefix byte.
  assign key_ev = ps2_key_pressed && !start && !brk &&
                  (ps2_key_data != PS2_BREAK) && (ps2_key_data != PS2_EXT);

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cand[p] = DIR_NONE;
      // Later k overwrites earlier, so the highest matching k wins.
      for (int k = 0; k < 4; k++) begin
        if (ps2_key_data == keymap[p*32 + k*8 +: 8]) cand[p] = 3'(k + 1);
      end
      ref_dir[p] = (queue_count[p*CNT_W +: CNT_W] != '0) ? tail[p]
                                                          : dir_out[p*3 +: 3];
      legal[p] = key_ev && (cand[p] != DIR_NONE) && (cand[p] != ref_dir[p]) &&
                 (cand[p] != opposite(ref_dir[p]));
      pop[p]   = game_tick && !start && (queue_count[p*CNT_W +: CNT_W] != '0);
      push[p]  = legal[p] && (!full[p] || pop[p]);
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
      dir_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .clear  (start),
        .push   (push[gp]),
        .pop    (pop[gp]),
        .din    (cand[gp]),
        .head   (head[gp]),
        .tail   (tail[gp]),
        .count  (queue_count[gp*CNT_W +: CNT_W]),
        .full   (full[gp])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      brk        <= 1'b0;
      dir_out    <= '0;
      turn_valid <= '0;
      overflow   <= '0;
    end else if (start) begin
      brk        <= 1'b0;
      turn_valid <= '0;
      overflow   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        // Codes above DIR_RIGHT are not directions; load them as DIR_NONE.
        dir_out[p*3 +: 3] <= (init_dir[p*3 +: 3] > DIR_RIGHT) ? DIR_NONE
                                                               : init_dir[p*3 +: 3];
      end
    end else begin
      if (ps2_key_pressed) begin
        if (ps2_key_data == PS2_BREAK)   brk <= 1'b1;
        else if (ps2_key_data != PS2_EXT) brk <= 1'b0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        turn_valid[p] <= pop[p];
        if (pop[p]) dir_out[p*3 +: 3] <= head[p];
        if (legal[p] && full[p] && !pop[p]) overflow[p] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_dir_queue.sv
module tb_player_dir_queue;

  localparam int NP = 2;
  localparam int QD = 4;
  localparam int CW = 3;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             ps2_key_pressed = 1'b0;
  logic [7:0]       ps2_key_data = 8'h00;
  logic [NP*32-1:0] keymap;
  logic             game_tick = 1'b0;
  logic             start = 1'b0;
  logic [NP*3-1:0]  init_dir = '0;
  logic [NP*3-1:0]  dir_out;
  logic [NP-1:0]    turn_valid;
  logic [NP*CW-1:0] queue_count;
  logic [NP-1:0]    overflow;

  player_dir_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .keymap          (keymap),
    .game_tick       (game_tick),
    .start           (start),
    .init_dir        (init_dir),
    .dir_out         (dir_out),
    .turn_valid      (turn_valid),
    .queue_count     (queue_count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model
  int mq [NP][$];
  int mdir [NP];
  bit mov [NP];
  bit mbrk;
  int sb [$];
  logic [7:0] codes [NP][4];

  function automatic int m_opp(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic load_keymap();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 4; k++) keymap[p*32 + k*8 +: 8] = codes[p][k];
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      mdir[p] = 0;
      mov[p]  = 0;
    end
    mbrk = 0;
    sb.delete();
  endtask

  task automatic model_step(input bit kp, input logic [7:0] kd, input bit tk,
                            input bit st, input logic [NP*3-1:0] ini);
    bit ev;
    int cand, r, sz;
    bit popping;
    if (st) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        mov[p]  = 0;
        mdir[p] = (int'(ini[p*3 +: 3]) > 4) ? 0 : int'(ini[p*3 +: 3]);
      end
      mbrk = 0;
      return;
    end
    ev = kp && !mbrk && kd != 8'hF0 && kd != 8'hE0;
    if (kp) begin
      if (kd == 8'hF0) mbrk = 1;
      else if (kd != 8'hE0) mbrk = 0;
    end
    for (int p = 0; p < NP; p++) begin
      cand = 0;
      for (int k = 0; k < 4; k++) if (kd == keymap[p*32 + k*8 +: 8]) cand = k + 1;
      sz = mq[p].size();
      r = (sz > 0) ? mq[p][sz-1] : mdir[p];
      popping = tk && sz > 0;
      if (popping) begin
        mdir[p] = mq[p].pop_front();
        sb.push_back(p*8 + mdir[p]);
      end
      if (ev && cand != 0 && cand != r && cand != m_opp(r)) begin
        if (sz < QD || popping) mq[p].push_back(cand);
        else mov[p] = 1;
      end
    end
  endtask

  task automatic check_state();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("dir_out[%0d]", p), int'(dir_out[p*3 +: 3]), mdir[p]);
      chk($sformatf("count[%0d]", p), int'(queue_count[p*CW +: CW]), mq[p].size());
      chk($sformatf("overflow[%0d]", p), int'(overflow[p]), int'(mov[p]));
    end
  endtask

  // Called just after a rising edge; the next edge captures the inputs.
  task automatic apply(input bit kp, input logic [7:0] kd, input bit tk,
                       input bit st, input logic [NP*3-1:0] ini);
    ps2_key_pressed = kp;
    ps2_key_data    = kd;
    game_tick       = tk;
    start           = st;
    init_dir        = ini;
    model_step(kp, kd, tk, st, ini);
    @(posedge clock);
    #1;
    ps2_key_pressed = 1'b0;
    game_tick       = 1'b0;
    start           = 1'b0;
    check_state();
  endtask

  task automatic key(input logic [7:0] kd);
    apply(1'b1, kd, 1'b0, 1'b0, '0);
  endtask

  task automatic tick();
    apply(1'b0, 8'h00, 1'b1, 1'b0, '0);
  endtask

  task automatic idle();
    apply(1'b0, 8'h00, 1'b0, 1'b0, '0);
  endtask

  task automatic restart(input logic [NP*3-1:0] ini);
    apply(1'b0, 8'h00, 1'b0, 1'b1, ini);
  endtask

  // Scoreboard consumer: every turn_valid pulse must match a queued pop.
  int tv0_pulses = 0;
  always @(negedge clock) begin : mon
    int e;
    if (resetn) begin
      for (int p = 0; p < NP; p++) begin
        if (turn_valid[p]) begin
          if (p == 0) tv0_pulses++;
          if (sb.size() == 0) chk("turn_unexpected", p*8 + int'(dir_out[p*3 +: 3]), -1);
          else begin
            e = sb.pop_front();
            chk("turn", p*8 + int'(dir_out[p*3 +: 3]), e);
          end
        end
      end
    end
  end

  initial begin
    int idx, p0start;
    logic [7:0] kd;
    codes[0] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    codes[1] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    load_keymap();
    model_reset();

    // Reset values
    #1;
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_count", int'(queue_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_tv", int'(turn_valid), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Start: P1=3, P0=1
    restart({3'd3, 3'd1});
    chk("start_dir0", int'(dir_out[2:0]), 1);
    chk("start_dir1", int'(dir_out[5:3]), 3);
    chk("start_tv", int'(turn_valid), 0);
    key(codes[0][1]);
    chk("rev_rejected", int'(queue_count[2:0]), 0);
    key(codes[0][2]);
    chk("left_queued", int'(queue_count[2:0]), 1);
    p0start = tv0_pulses;
    tick();
    chk("tick_dir0", int'(dir_out[2:0]), 3);
    chk("tick_tv0", int'(turn_valid[0]), 1);
    idle();
    chk("tv_one_cycle", int'(turn_valid[0]), 0);
    idle();
    chk("tv0_pulse_count", tv0_pulses - p0start, 1);

    // Break sequence, and E0 inside it
    restart({3'd3, 3'd1});
    key(8'hF0);
    key(codes[0][2]);
    chk("break_consumed", int'(queue_count[2:0]), 0);
    key(codes[0][3]);
    chk("after_break", int'(queue_count[2:0]), 1);
    restart({3'd3, 3'd1});
    key(8'hF0);
    key(8'hE0);
    key(codes[0][2]);
    chk("e0_keeps_break", int'(queue_count[2:0]), 0);
    key(codes[0][2]);
    chk("left_after_e0", int'(queue_count[2:0]), 1);

    // Overflow: 5 alternating turns into a 4-deep queue
    restart({3'd3, 3'd1});
    key(codes[0][2]); key(codes[0][0]); key(codes[0][2]); key(codes[0][0]);
    key(codes[0][2]);
    chk("full_count", int'(queue_count[2:0]), 4);
    chk("overflow_set", int'(overflow[0]), 1);
    // Push + tick while full: pop head, append at wrapped tail
    apply(1'b1, codes[0][2], 1'b1, 1'b0, '0);
    chk("full_pushpop_count", int'(queue_count[2:0]), 4);
    chk("full_pushpop_dir", int'(dir_out[2:0]), 3);
    chk("overflow_sticky", int'(overflow[0]), 1);
    repeat (4) tick();
    chk("drained_dir", int'(dir_out[2:0]), 3);
    restart({3'd0, 3'd0});
    chk("overflow_cleared", int'(overflow[0]), 0);

    // Highest k wins; a shared code goes to both players
    codes[0][3] = codes[0][2];
    codes[1][2] = codes[0][2];
    load_keymap();
    key(codes[0][2]);
    chk("highest_k", int'(queue_count[2:0]), 1);
    chk("shared_code", int'(queue_count[5:3]), 1);
    tick();
    chk("highest_k_dir", int'(dir_out[2:0]), 4);
    chk("shared_dir", int'(dir_out[5:3]), 3);
    codes[0] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    codes[1] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    load_keymap();
    restart({3'd7, 3'd5});
    chk("init_sanitize", int'(dir_out), 0);

    // Async reset mid-queue
    restart({3'd3, 3'd1});
    key(codes[0][2]); key(codes[0][0]); key(codes[0][2]);
    chk("pre_rst_count", int'(queue_count[2:0]), 3);
    tick();
    idle();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_dir", int'(dir_out), 0);
    chk("arst_count", int'(queue_count), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_tv", int'(turn_valid), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    key(codes[0][1]);
    chk("post_rst_accept", int'(queue_count[2:0]), 1);
    tick();
    chk("post_rst_dir", int'(dir_out[2:0]), 2);

    // Random traffic against the model
    repeat (400) begin
      idx = $urandom_range(0, 9);
      kd = (idx == 8) ? 8'hF0 : (idx == 9) ? 8'hE0 : codes[idx/4][idx%4];
      apply($urandom_range(0, 1) == 0, kd, $urandom_range(0, 3) == 0,
            $urandom_range(0, 60) == 0, 6'($urandom()));
    end

    repeat (3) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
